// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, mode codes and BCD helpers for stopwatch_timer_core
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [1:0] MODE_UP0 = 2'b00;
  localparam logic [1:0] MODE_UPP = 2'b01;
  localparam logic [1:0] MODE_DNMAX = 2'b10;
  localparam logic [1:0] MODE_DNP = 2'b11;
  localparam logic [3:0] BCD_NINE = 4'd9;
  function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
    return n > BCD_NINE ? BCD_NINE : n;
  endfunction
endpackage

// File: rtl/stopwatch_timer_core_if.sv
// stopwatch_timer_core_if: control pulses, mode/preset in; count, display, done, running, lap_active out
interface stopwatch_timer_core_if #(parameter int DIGITS = 4, parameter int PRESET_DIGITS = 2);
  logic tick;
  logic [1:0] mode;
  logic [4*PRESET_DIGITS-1:0] preset;
  logic load;
  logic start;
  logic stop;
  logic lap;
  logic [4*DIGITS-1:0] count;
  logic [4*DIGITS-1:0] display;
  logic done;
  logic running;
  logic lap_active;
  modport master (output tick, mode, preset, load, start, stop, lap, input count, display, done, running, lap_active);
  modport slave (input tick, mode, preset, load, start, stop, lap, output count, display, done, running, lap_active);
endinterface

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit; clk/reset, en/up step, load/load_val init, q value, d next value, co carry/borrow, term at 9 (up) or 0 (down)
module bcd_digit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic [3:0] d,
  output logic       co,
  output logic       term
);
  assign term = up ? q == 4'd9 : q == 4'd0;
  assign co = en & term;
  always_comb d = load ? load_val : !en ? q : up ? (q == 4'd9 ? 4'd0 : q + 4'd1) : (q == 4'd0 ? 4'd9 : q - 4'd1);
  always_ff @(posedge clk)
    q <= reset ? 4'd0 : d;
endmodule

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: BCD stopwatch with run/pause/done FSM and lap hold; clk, reset, bus (slave side of stopwatch_timer_core_if)
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int PRESET_DIGITS = 2
) (
  input logic clk,
  input logic reset,
  stopwatch_timer_core_if.slave bus
);
  localparam int LO = DIGITS - PRESET_DIGITS;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state, st_n, mode_q;
  logic up, at_term, near_term, cnt_en, lap_active, lap_act_n, done, running, unused_co;
  logic [4*DIGITS-1:0] count, count_n, lap_value, lap_val_n, display;
  logic [DIGITS-1:0] en, co, term;
  logic [3:0] lv [DIGITS];
  assign up = ~mode_q[1];
  assign at_term = &term;
  // the step about to happen lands on terminal when every upper digit already is and digit 0 is one step away
  assign near_term = &term[DIGITS-1:1] && count[3:0] == (up ? 4'd8 : 4'd1);
  assign cnt_en = !bus.load && state == S_RUN && !bus.stop && bus.tick;
  assign en = {co[DIGITS-2:0], cnt_en};
  assign unused_co = co[DIGITS-1];
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_dig
    if (g >= LO) begin : g_p
      assign lv[g] = bus.mode[0] ? clamp_bcd(bus.preset[4*(g-LO) +: 4]) : bus.mode == MODE_DNMAX ? BCD_NINE : 4'd0;
    end else begin : g_z
      assign lv[g] = bus.mode == MODE_DNMAX ? BCD_NINE : 4'd0;
    end
    bcd_digit_counter u_dig (
      .clk(clk),
      .reset(reset),
      .en(en[g]),
      .up(up),
      .load(bus.load),
      .load_val(lv[g]),
      .q(count[4*g +: 4]),
      .d(count_n[4*g +: 4]),
      .co(co[g]),
      .term(term[g])
    );
  end
  always_comb begin
    st_n = state;
    lap_act_n = lap_active;
    lap_val_n = lap_value;
    if (bus.load) begin
      st_n = S_IDLE;
      lap_act_n = 1'b0;
    end else if (state == S_RUN && bus.stop) begin
      st_n = S_PAUSE;
    end else if ((state == S_IDLE || state == S_PAUSE) && bus.start) begin
      st_n = at_term ? S_DONE : S_RUN;
    end else if (state == S_RUN) begin
      lap_act_n = bus.lap ? ~lap_active : lap_active;
      lap_val_n = bus.lap && !lap_active ? count : lap_value;
      st_n = bus.tick && near_term ? S_DONE : S_RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mode_q <= MODE_UP0;
      lap_active <= 1'b0;
      lap_value <= '0;
      done <= 1'b0;
      running <= 1'b0;
      display <= '0;
    end else begin
      state <= st_n;
      mode_q <= bus.load ? bus.mode : mode_q;
      lap_active <= lap_act_n;
      lap_value <= lap_val_n;
      done <= st_n == S_DONE;
      running <= st_n == S_RUN;
      display <= lap_act_n ? lap_val_n : count_n;
    end
  end
  assign bus.count = count;
  assign bus.display = display;
  assign bus.done = done;
  assign bus.running = running;
  assign bus.lap_active = lap_active;
endmodule

// File: tb/tb_stopwatch_timer_core.sv
// tb_stopwatch_timer_core: table-driven vectors plus multi-cycle sequences for stopwatch_timer_core
module tb_stopwatch_timer_core;
  typedef struct {
    logic [4:0] ctl;
    logic [1:0] m;
    logic [7:0] p;
    logic [15:0] c;
    logic [15:0] d;
    logic [2:0] f;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t v [17];
  stopwatch_timer_core_if #(.DIGITS(4), .PRESET_DIGITS(2)) bus ();
  stopwatch_timer_core #(.DIGITS(4), .PRESET_DIGITS(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [15:0] c, input logic [15:0] d, input logic [2:0] f);
    chk({nm, " count"}, bus.count, c);
    chk({nm, " display"}, bus.display, d);
    chk({nm, " done/run/lap"}, {13'd0, bus.done, bus.running, bus.lap_active}, {13'd0, f});
  endtask
  task automatic cyc(input logic [4:0] ctl, input logic [1:0] m, input logic [7:0] p);
    {bus.tick, bus.load, bus.start, bus.stop, bus.lap} = ctl;
    bus.mode = m;
    bus.preset = p;
    @(posedge clk);
    #1;
    {bus.tick, bus.load, bus.start, bus.stop, bus.lap} = 5'b0;
  endtask
  task automatic ticks(input int n);
    repeat (n) cyc(5'b10000, 2'b00, 8'h00);
  endtask
  initial begin
    v[0] = '{5'b01000, 2'b01, 8'h47, 16'h4700, 16'h4700, 3'b000};
    v[1] = '{5'b01000, 2'b01, 8'h4C, 16'h4900, 16'h4900, 3'b000};
    v[2] = '{5'b01000, 2'b10, 8'h00, 16'h9999, 16'h9999, 3'b000};
    v[3] = '{5'b00100, 2'b00, 8'h00, 16'h9999, 16'h9999, 3'b010};
    v[4] = '{5'b10000, 2'b00, 8'h00, 16'h9998, 16'h9998, 3'b010};
    v[5] = '{5'b10010, 2'b00, 8'h00, 16'h9998, 16'h9998, 3'b000};
    v[6] = '{5'b10000, 2'b00, 8'h00, 16'h9998, 16'h9998, 3'b000};
    v[7] = '{5'b00100, 2'b00, 8'h00, 16'h9998, 16'h9998, 3'b010};
    v[8] = '{5'b10001, 2'b00, 8'h00, 16'h9997, 16'h9998, 3'b011};
    v[9] = '{5'b10000, 2'b00, 8'h00, 16'h9996, 16'h9998, 3'b011};
    v[10] = '{5'b00001, 2'b00, 8'h00, 16'h9996, 16'h9996, 3'b010};
    v[11] = '{5'b01000, 2'b11, 8'h00, 16'h0000, 16'h0000, 3'b000};
    v[12] = '{5'b00100, 2'b00, 8'h00, 16'h0000, 16'h0000, 3'b100};
    v[13] = '{5'b10000, 2'b00, 8'h00, 16'h0000, 16'h0000, 3'b100};
    v[14] = '{5'b01000, 2'b00, 8'h00, 16'h0000, 16'h0000, 3'b000};
    v[15] = '{5'b10100, 2'b00, 8'h00, 16'h0000, 16'h0000, 3'b010};
    v[16] = '{5'b10000, 2'b00, 8'h00, 16'h0001, 16'h0001, 3'b010};
    {bus.tick, bus.load, bus.start, bus.stop, bus.lap} = 5'b0;
    bus.mode = 2'b00;
    bus.preset = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 16'h0000, 16'h0000, 3'b000);
    for (int i = 0; i < 17; i++) begin
      cyc(v[i].ctl, v[i].m, v[i].p);
      chk_all($sformatf("vec%0d", i), v[i].c, v[i].d, v[i].f);
    end
    cyc(5'b01000, 2'b00, 8'h00);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(9998);
    chk_all("up0 9998", 16'h9998, 16'h9998, 3'b010);
    ticks(1);
    chk_all("up0 9999", 16'h9999, 16'h9999, 3'b100);
    ticks(1);
    chk_all("up0 hold", 16'h9999, 16'h9999, 3'b100);
    cyc(5'b01000, 2'b01, 8'h47);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(99);
    chk_all("upp 4799", 16'h4799, 16'h4799, 3'b010);
    ticks(1);
    chk_all("upp 4800", 16'h4800, 16'h4800, 3'b010);
    cyc(5'b01000, 2'b11, 8'h01);
    chk_all("dnp load", 16'h0100, 16'h0100, 3'b000);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(99);
    chk_all("dnp 0001", 16'h0001, 16'h0001, 3'b010);
    ticks(1);
    chk_all("dnp 0000", 16'h0000, 16'h0000, 3'b100);
    cyc(5'b01000, 2'b00, 8'h00);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(12);
    cyc(5'b10010, 2'b00, 8'h00);
    chk_all("stop+tick", 16'h0012, 16'h0012, 3'b000);
    ticks(3);
    chk_all("pause ticks", 16'h0012, 16'h0012, 3'b000);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(1);
    chk_all("resume", 16'h0013, 16'h0013, 3'b010);
    cyc(5'b01000, 2'b00, 8'h00);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(50);
    cyc(5'b10001, 2'b00, 8'h00);
    chk_all("lap+tick", 16'h0051, 16'h0050, 3'b011);
    ticks(10);
    chk_all("lap hold", 16'h0061, 16'h0050, 3'b011);
    cyc(5'b00001, 2'b00, 8'h00);
    chk_all("lap release", 16'h0061, 16'h0061, 3'b010);
    cyc(5'b01000, 2'b10, 8'h00);
    cyc(5'b01000, 2'b00, 8'h00);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(300);
    chk_all("pre reset", 16'h0300, 16'h0300, 3'b010);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("mid reset", 16'h0000, 16'h0000, 3'b000);
    cyc(5'b00100, 2'b00, 8'h00);
    ticks(1);
    chk_all("post reset", 16'h0001, 16'h0001, 3'b010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised BCD timer datapath and control for the digital stopwatch, successor to the fixed 4-digit, 14-bit binary datapath. It counts directly in packed BCD across `DIGITS` digits in four modes: up from zero, up from preset, down from max, down from preset. It owns the run/pause/done state machine and a lap-hold register. It sits between the debounced button/tick logic and the seven-segment display driver, so no binary-to-BCD conversion is needed downstream.

## Interface
- `DIGITS`, 4: number of BCD digits counted and displayed (≥2).
- `PRESET_DIGITS`, 2: preset width in digits; the preset loads into the most-significant `PRESET_DIGITS` digits, lower digits zero (≤`DIGITS`).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle count-enable pulse (timebase, e.g. 10 ms).
- `mode` input 2: 00 up-from-0, 01 up-from-preset, 10 down-from-max, 11 down-from-preset. Sampled only on `load`.
- `preset` input 4*PRESET_DIGITS: packed BCD preset. Any nibble >9 is clamped to 9 at load.
- `load` input 1: pulse; initialises the count for `mode` and enters IDLE.
- `start` input 1: pulse; run from IDLE or PAUSE.
- `stop` input 1: pulse; pause from RUN.
- `lap` input 1: pulse; toggles lap hold while in RUN.
- `count` output 4*DIGITS: live packed BCD count.
- `display` output 4*DIGITS: `lap_value` when `lap_active`, else `count`.
- `done` output 1: terminal value reached; registered.
- `running` output 1: high in RUN.
- `lap_active` output 1: display frozen on lap value.

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset: state IDLE, mode_q=00, count=0, lap_value=0, done=0, running=0, lap_active=0, display=0.
- `load` is accepted in any state.
  - Sets count to: 0 (mode 00); preset followed by zeros (modes 01 and 11); all 9s (mode 10).
  - Latches mode_q, clears done and lap_active, and enters IDLE.
- `start` in IDLE/PAUSE:
  - Goes to DONE and sets done if count is already terminal.
  - Otherwise goes to RUN.
  - Ignored in RUN and DONE.
- `stop` in RUN: goes to PAUSE. Ignored elsewhere.
- RUN with `tick`:
  - Up modes: increment by 1. Each digit wraps 9→0 and carries upward.
  - Down modes: decrement by 1. Each digit wraps 0→9 and borrows upward.
- Terminal value: all 9s for up modes, all 0s for down modes.
  - The increment/decrement that produces the terminal value also moves the state to DONE and sets done, on the same edge.
  - The count never wraps past terminal. Ticks in DONE are ignored.
- Lap:
  - First `lap` in RUN copies count into lap_value and sets lap_active.
  - Next `lap` in RUN clears lap_active.
  - `lap` in other states is ignored.
  - lap_active persists through PAUSE and DONE until `load` or `reset`.
- Simultaneous-event priority: reset > load > stop > start > lap > tick.
  - `stop`+`tick` in RUN: pause, no count.
  - `start`+`tick` in IDLE: enter RUN, tick not counted.
  - `lap`+`tick` in RUN: lap_value captures the pre-increment count, and the count still advances.

## Timing
- Every output changes only on the `clk` rising edge.
- Count update latency: 1 cycle after `tick` is sampled high.
- `done`, `running` and `display` reflect the new state in the same cycle as `count`.
- `load`/`start`/`stop`/`lap` take effect on the edge they are sampled. No handshake; they are single-cycle pulses.
- A `reset` mid-RUN returns every output to its reset value on the next edge.

## Structure
- `stopwatch_pkg`:
  - state enum (IDLE/RUN/PAUSE/DONE);
  - mode constants MODE_UP0, MODE_UPP, MODE_DNMAX, MODE_DNP;
  - BCD_NINE.
- Sub-module `bcd_digit_counter`: one digit, with `en`, `up`, `load`, `load_val[3:0]`, `q[3:0]`, and carry/borrow out (`co` asserted when en & (up ? q==9 : q==0)).
  - Instantiated `DIGITS` times in a ripple-enable chain.
  - Terminal detect is the AND of the per-digit terminal flags.

## Test plan
- DIGITS=4, mode 00, load, start, 9999 ticks: count=9999 and done=1 on the 9999th tick edge. A further tick leaves count at 9999.
- Mode 01, preset=0x47: load gives 4700. Start, 100 ticks gives 4800 (carry 4799→4800). A preset of 0x4C loads as 4900.
- Mode 11, preset=0x01: load gives 0100. Start, 100 ticks gives 0000 with done=1 and running=0. Mode 10 load gives 9999, and one tick gives 9998.
- Pause: RUN at 0012, `stop`+`tick` same cycle gives count 0012 in PAUSE. Ticks are ignored. `start`, then one tick, gives 0013.
- Lap: RUN at 0050, `lap`+`tick` gives display=0050, count=0051, lap_active=1. Ten ticks leave display at 0050. A second `lap` makes display equal count (0061).
- `reset` asserted mid-RUN at count 0300 gives all outputs 0 and IDLE on the next edge. `start` without `load` then counts up from 0000.
